// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Three-way arbiter in front of a single-port, one-cycle-latency VRAM.
//   The 6809 CPU has absolute priority. The vector generator (read-only) and
//   the host share the remaining slots round-robin. Each access runs
//   IDLE/ACK -> ISSUE -> CAPTURE -> ACK. Back-to-back grants from ACK give a
//   3-cycle throughput.
//
//   Optional feature macro: VRAM_ARB_STATS_EN
//     defined   : conflict_count counts cycles in which the VG was eligible
//                 but not granted. It saturates at 0xFFFF and is cleared only
//                 by reset.
//     undefined : the counter logic is absent and conflict_count reads 0.
//
// Ports
//   clk_12, reset_n          clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request level, write strobe, address, data
//   cpu_ack/cpu_rdata        CPU completion pulse, registered read data
//   vg_req/vg_addr           vector-generator read request
//   vg_ack/vg_rdata          VG completion pulse, read data
//   host_req/we/addr/wdata   host request (already in the clk_12 domain)
//   host_ack/host_rdata      host completion pulse, read data
//   ram_addr/ram_we/ram_wdata registered VRAM controls
//   ram_rdata                VRAM read data, valid one cycle after ram_addr
//   conflict_count           VG wait statistics
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk_12,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vg_req,
  input  logic [ADDR_W-1:0] vg_addr,
  output logic              vg_ack,
  output logic [DATA_W-1:0] vg_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       conflict_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  localparam logic [1:0] OWN_CPU  = 2'd0;
  localparam logic [1:0] OWN_VG   = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  localparam logic LW_VG   = 1'b0;
  localparam logic LW_HOST = 1'b1;

  state_t            state_q;
  logic [1:0]        owner_q;
  logic              acc_we_q;
  logic              last_winner_q;
  logic              cpu_served_q, vg_served_q, host_served_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              cpu_ack_q, vg_ack_q, host_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q, vg_rdata_q, host_rdata_q;

  logic              cpu_acking_s, vg_acking_s, host_acking_s;
  logic              cpu_elig_s, vg_elig_s, host_elig_s;
  logic              grant_valid_d;
  logic [1:0]        grant_owner_d;
  logic              grant_we_d;
  logic [ADDR_W-1:0] grant_addr_d;
  logic [DATA_W-1:0] grant_wdata_d;
  logic              cpu_served_d, vg_served_d, host_served_d;

  // Eligibility, fixed-priority/round-robin grant and the served-flag update.
  always_comb begin
    // The requester being acknowledged this cycle counts as already served,
    // so a held request is not granted a second time from ACK.
    cpu_acking_s  = (state_q == ST_ACK) && (owner_q == OWN_CPU);
    vg_acking_s   = (state_q == ST_ACK) && (owner_q == OWN_VG);
    host_acking_s = (state_q == ST_ACK) && (owner_q == OWN_HOST);

    cpu_elig_s  = cpu_req  && !cpu_served_q  && !cpu_acking_s;
    vg_elig_s   = vg_req   && !vg_served_q   && !vg_acking_s;
    host_elig_s = host_req && !host_served_q && !host_acking_s;

    grant_valid_d = 1'b0;
    grant_owner_d = OWN_CPU;
    if ((state_q == ST_IDLE) || (state_q == ST_ACK)) begin
      if (cpu_elig_s) begin
        grant_valid_d = 1'b1;
        grant_owner_d = OWN_CPU;
      end else if (vg_elig_s && host_elig_s) begin
        grant_valid_d = 1'b1;
        grant_owner_d = (last_winner_q == LW_HOST) ? OWN_VG : OWN_HOST;
      end else if (vg_elig_s) begin
        grant_valid_d = 1'b1;
        grant_owner_d = OWN_VG;
      end else if (host_elig_s) begin
        grant_valid_d = 1'b1;
        grant_owner_d = OWN_HOST;
      end else begin
        grant_valid_d = 1'b0;
        grant_owner_d = OWN_CPU;
      end
    end else begin
      grant_valid_d = 1'b0;
      grant_owner_d = OWN_CPU;
    end

    // VG never writes; its grants keep the previous write-data value.
    case (grant_owner_d)
      OWN_CPU: begin
        grant_we_d    = cpu_we;
        grant_addr_d  = cpu_addr;
        grant_wdata_d = cpu_wdata;
      end
      OWN_VG: begin
        grant_we_d    = 1'b0;
        grant_addr_d  = vg_addr;
        grant_wdata_d = ram_wdata_q;
      end
      OWN_HOST: begin
        grant_we_d    = host_we;
        grant_addr_d  = host_addr;
        grant_wdata_d = host_wdata;
      end
      default: begin
        grant_we_d    = 1'b0;
        grant_addr_d  = {ADDR_W{1'b0}};
        grant_wdata_d = ram_wdata_q;
      end
    endcase

    if (cpu_req) begin
      cpu_served_d = cpu_served_q | cpu_acking_s;
    end else begin
      cpu_served_d = 1'b0;
    end
    if (vg_req) begin
      vg_served_d = vg_served_q | vg_acking_s;
    end else begin
      vg_served_d = 1'b0;
    end
    if (host_req) begin
      host_served_d = host_served_q | host_acking_s;
    end else begin
      host_served_d = 1'b0;
    end
  end

  // Access sequencer: latches the granted request and drives the RAM/ack/rdata registers.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_CPU;
      acc_we_q      <= 1'b0;
      last_winner_q <= LW_HOST;
      cpu_served_q  <= 1'b0;
      vg_served_q   <= 1'b0;
      host_served_q <= 1'b0;
      ram_addr_q    <= {ADDR_W{1'b0}};
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= {DATA_W{1'b0}};
      cpu_ack_q     <= 1'b0;
      vg_ack_q      <= 1'b0;
      host_ack_q    <= 1'b0;
      cpu_rdata_q   <= {DATA_W{1'b0}};
      vg_rdata_q    <= {DATA_W{1'b0}};
      host_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      cpu_served_q  <= cpu_served_d;
      vg_served_q   <= vg_served_d;
      host_served_q <= host_served_d;
      cpu_ack_q     <= 1'b0;
      vg_ack_q      <= 1'b0;
      host_ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE, ST_ACK: begin
          if (grant_valid_d) begin
            state_q     <= ST_ISSUE;
            owner_q     <= grant_owner_d;
            acc_we_q    <= grant_we_d;
            ram_addr_q  <= grant_addr_d;
            ram_we_q    <= grant_we_d;
            ram_wdata_q <= grant_wdata_d;
            // CPU grants leave the VG/host rotation untouched.
            if (grant_owner_d != OWN_CPU) begin
              last_winner_q <= (grant_owner_d == OWN_VG) ? LW_VG : LW_HOST;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          ram_we_q <= 1'b0;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q <= ST_ACK;
          case (owner_q)
            OWN_CPU: begin
              cpu_ack_q <= 1'b1;
              if (!acc_we_q) cpu_rdata_q <= ram_rdata;
            end
            OWN_VG: begin
              vg_ack_q   <= 1'b1;
              vg_rdata_q <= ram_rdata;
            end
            OWN_HOST: begin
              host_ack_q <= 1'b1;
              if (!acc_we_q) host_rdata_q <= ram_rdata;
            end
            default: begin
            end
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic        vg_wait_s;
  logic [15:0] conflict_q;
  logic [15:0] conflict_d;

  // Saturating count of cycles the VG is eligible but loses the grant.
  always_comb begin
    vg_wait_s = vg_elig_s && !(grant_valid_d && (grant_owner_d == OWN_VG));
    if (vg_wait_s && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict counter register; cleared only by reset.
  always_ff @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q <= 16'h0000;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = 16'h0000;
`endif

  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vg_ack     = vg_ack_q;
  assign vg_rdata   = vg_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: transaction-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_vram_arbiter;

  logic        clk_12 = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] cpu_addr = 14'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vg_req = 1'b0;
  logic [13:0] vg_addr = 14'h0;
  logic        vg_ack;
  logic [7:0]  vg_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [13:0] host_addr = 14'h0;
  logic [7:0]  host_wdata = 8'h0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h0;
  logic [15:0] conflict_count;

  int checks = 0;
  int failures = 0;
  int n_cpu_ack = 0, n_vg_ack = 0, n_host_ack = 0;
  int a0;

`ifdef VRAM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  vram_arbiter #(.ADDR_W(14), .DATA_W(8)) dut (
    .clk_12(clk_12), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vg_req(vg_req), .vg_addr(vg_addr), .vg_ack(vg_ack), .vg_rdata(vg_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_count(conflict_count)
  );

  always #5 clk_12 = ~clk_12;

  function automatic logic [7:0] pre_val(input logic [13:0] a);
    if (a == 14'h2000) return 8'h3C;
    return a[7:0] ^ 8'h5A;
  endfunction

  // VRAM: synchronous write, registered read
  logic [7:0] mem    [0:16383];
  logic [7:0] shadow [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]    = pre_val(14'(i));
      shadow[i] = pre_val(14'(i));
    end
  end
  always @(posedge clk_12) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (requesters 0=cpu 1=vg 2=host) --------
  bit          m_served [3];
  int          m_last = 2;
  bit          fl_valid = 1'b0;
  int          fl_who = 0, fl_age = 0;
  bit          fl_we = 1'b0;
  logic [13:0] fl_addr = 14'h0;
  logic [7:0]  fl_wd;
  logic [13:0] m_ram_addr = 14'h0;
  logic        m_ram_we = 1'b0;
  logic [7:0]  m_ram_wdata = 8'h0;
  bit          m_ack [3];
  logic [7:0]  m_rdata [3];
  int          m_cnt = 0;
  bit          rq [3];
  bit          el [3];
  int          acking, win;
  bit          open_slot;

  always @(posedge clk_12 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        m_served[i] = 1'b0; m_ack[i] = 1'b0; m_rdata[i] = 8'h00;
      end
      m_last = 2; fl_valid = 1'b0; fl_age = 0;
      m_ram_addr = 14'h0; m_ram_we = 1'b0; m_ram_wdata = 8'h0; m_cnt = 0;
    end else begin
      rq[0] = cpu_req; rq[1] = vg_req; rq[2] = host_req;
      acking = (fl_valid && fl_age == 3) ? fl_who : -1;
      open_slot = !fl_valid || (fl_age == 3);
      for (int i = 0; i < 3; i++) el[i] = rq[i] && !m_served[i] && (i != acking);
      win = -1;
      if (open_slot) begin
        if (el[0]) win = 0;
        else if (el[1] && el[2]) win = (m_last == 1) ? 2 : 1;
        else if (el[1]) win = 1;
        else if (el[2]) win = 2;
      end
      if (el[1] && win != 1 && m_cnt < 65535) m_cnt++;
      for (int i = 0; i < 3; i++) m_served[i] = rq[i] && (m_served[i] || i == acking);
      if (fl_valid) begin
        if (fl_age == 3) fl_valid = 1'b0;
        else fl_age++;
      end
      if (win >= 0) begin
        fl_valid = 1'b1; fl_age = 1; fl_who = win;
        if (win == 0) begin fl_we = cpu_we; fl_addr = cpu_addr; fl_wd = cpu_wdata; end
        else if (win == 1) begin fl_we = 1'b0; fl_addr = vg_addr; fl_wd = m_ram_wdata; end
        else begin fl_we = host_we; fl_addr = host_addr; fl_wd = host_wdata; end
        m_ram_addr = fl_addr; m_ram_wdata = fl_wd;
        if (fl_we) shadow[fl_addr] = fl_wd;
        if (win != 0) m_last = win;
      end
      m_ram_we = fl_valid && fl_age == 1 && fl_we;
      for (int i = 0; i < 3; i++) m_ack[i] = fl_valid && fl_age == 3 && fl_who == i;
      if (fl_valid && fl_age == 3 && !fl_we) m_rdata[fl_who] = shadow[fl_addr];
    end
  end

  // Per-cycle comparison against the model, plus ack pulse counters
  always @(negedge clk_12) begin
    check("m_cpu_ack", 32'(cpu_ack), 32'(m_ack[0]));
    check("m_vg_ack", 32'(vg_ack), 32'(m_ack[1]));
    check("m_host_ack", 32'(host_ack), 32'(m_ack[2]));
    check("m_cpu_rdata", 32'(cpu_rdata), 32'(m_rdata[0]));
    check("m_vg_rdata", 32'(vg_rdata), 32'(m_rdata[1]));
    check("m_host_rdata", 32'(host_rdata), 32'(m_rdata[2]));
    check("m_ram_we", 32'(ram_we), 32'(m_ram_we));
    check("m_ram_addr", 32'(ram_addr), 32'(m_ram_addr));
    check("m_ram_wdata", 32'(ram_wdata), 32'(m_ram_wdata));
    check("m_conflict", 32'(conflict_count), STATS ? 32'(m_cnt) : 32'd0);
    check("one_ack", 32'(int'(cpu_ack) + int'(vg_ack) + int'(host_ack) <= 1), 32'd1);
    if (cpu_ack)  n_cpu_ack++;
    if (vg_ack)   n_vg_ack++;
    if (host_ack) n_host_ack++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_12);
      #1;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, vg_rdata, host_rdata}), 32'd0);
    check("rst_conflict", 32'(conflict_count), 32'd0);
    reset_n = 1'b1;

    // CPU write 0x0123 <- 0xA5 alone
    step(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'hA5;
    step(1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("wr_ram_we_c1", 32'(ram_we), 32'd1);
    check("wr_ram_addr_c1", 32'(ram_addr), 32'h0123);
    check("wr_ram_wdata_c1", 32'(ram_wdata), 32'hA5);
    step(1);
    check("wr_ram_we_c2", 32'(ram_we), 32'd0);
    step(1);
    check("wr_cpu_ack_c3", 32'(cpu_ack), 32'd1);
    check("wr_vram", 32'(mem[14'h0123]), 32'hA5);
    check("wr_rdata_held", 32'(cpu_rdata), 32'd0);
    step(1);
    check("wr_cpu_ack_c4", 32'(cpu_ack), 32'd0);

    // VG and host together: VG first, host next, then VG again
    vg_req = 1'b1; vg_addr = 14'h0111;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0222;
    step(3);
    check("rr_vg_ack_c3", 32'(vg_ack), 32'd1);
    check("rr_host_ack_c3", 32'(host_ack), 32'd0);
    check("rr_vg_rdata", 32'(vg_rdata), 32'h4B);
    step(3);
    check("rr_host_ack_c6", 32'(host_ack), 32'd1);
    check("rr_host_rdata", 32'(host_rdata), 32'h78);
    step(1);
    vg_req = 1'b0; host_req = 1'b0;
    step(1);
    vg_req = 1'b1; vg_addr = 14'h0155;
    host_req = 1'b1; host_addr = 14'h0266;
    step(3);
    check("rr2_vg_ack", 32'(vg_ack), 32'd1);
    check("rr2_vg_rdata", 32'(vg_rdata), 32'h0F);
    step(3);
    check("rr2_host_ack", 32'(host_ack), 32'd1);
    check("rr2_host_rdata", 32'(host_rdata), 32'h3C);
    step(1);
    vg_req = 1'b0; host_req = 1'b0;
    step(1);

    // Host read in flight, CPU arrives during ISSUE
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0333;
    step(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0444;
    step(2);
    check("pre_host_ack", 32'(host_ack), 32'd1);
    check("pre_host_rdata", 32'(host_rdata), 32'h69);
    check("pre_cpu_ack_early", 32'(cpu_ack), 32'd0);
    step(1);
    cpu_req = 1'b0; host_req = 1'b0;
    check("pre_cpu_issue_addr", 32'(ram_addr), 32'h0444);
    step(2);
    check("pre_cpu_ack_wait5", 32'(cpu_ack), 32'd1);
    check("pre_cpu_rdata", 32'(cpu_rdata), 32'h1E);
    step(1);

    // CPU request held 8 cycles: one access only
    a0 = n_cpu_ack;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h2000;
    step(3);
    check("hold_cpu_ack_c3", 32'(cpu_ack), 32'd1);
    step(5);
    cpu_req = 1'b0;
    step(3);
    check("hold_one_ack", 32'(n_cpu_ack - a0), 32'd1);
    check("hold_cpu_rdata", 32'(cpu_rdata), 32'h3C);

    // Reset during ISSUE of a host write
    a0 = n_host_ack;
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0456; host_wdata = 8'h77;
    step(1);
    check("rst_issue_we", 32'(ram_we), 32'd1);
    reset_n = 1'b0; host_req = 1'b0; host_we = 1'b0;
    #1;
    check("rst_async_we", 32'(ram_we), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("rst_no_write", 32'(mem[14'h0456]), 32'h0C);
    check("rst_no_ack", 32'(n_host_ack - a0), 32'd0);
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0456; host_wdata = 8'h77;
    step(3);
    check("rst_retry_ack", 32'(host_ack), 32'd1);
    check("rst_retry_rdata", 32'(host_rdata), 32'd0);
    step(1);
    host_req = 1'b0; host_we = 1'b0;
    check("rst_retry_vram", 32'(mem[14'h0456]), 32'h77);
    check("rst_retry_count", 32'(n_host_ack - a0), 32'd1);

    // VG starved by CPU/host traffic: 10 waiting cycles
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check("st_reset", 32'(conflict_count), 32'd0);
    step(1);
    vg_req = 1'b1; vg_addr = 14'h0010;
    step(1);
    vg_req = 1'b0;
    step(3);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0020;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0030;
    vg_req = 1'b1; vg_addr = 14'h0040;
    step(4);
    check("st_host_beats_vg", 32'(ram_addr), 32'h0030);
    cpu_req = 1'b0;
    step(1);
    cpu_req = 1'b1;
    step(2);
    check("st_cpu_again", 32'(ram_addr), 32'h0020);
    step(3);
    check("st_vg_finally", 32'(ram_addr), 32'h0040);
    cpu_req = 1'b0; host_req = 1'b0; vg_req = 1'b0;
    step(3);
    cpu_req = 1'b1; cpu_addr = 14'h0050;
    step(1);
    cpu_req = 1'b0;
    step(1);
    vg_req = 1'b1; vg_addr = 14'h0060;
    step(2);
    vg_req = 1'b0;
    check("st_vg_addr", 32'(ram_addr), 32'h0060);
    step(3);
    check("st_count", 32'(conflict_count), STATS ? 32'd10 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
